// File: rtl/tlb_op_seq_pkg.sv
// tlb_op_seq_pkg: op encodings and FSM states shared by the TLB op sequencer
package tlb_op_seq_pkg;
  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;
  localparam logic [4:0] INV_OP_MAX = 5'd6;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_CAP,
    S_WRITE,
    S_INV_SCAN,
    S_DONE
  } state_t;
endpackage

// File: rtl/tlb_op_seq_fill_ctr.sv
// tlb_fill_ctr: free-running counter that wraps at TLBNUM-1, picking tlbfill victims
module tlb_fill_ctr #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] cnt
);
  // explicit wrap so non-power-of-2 TLBNUM never yields an out-of-range index
  always_ff @(posedge clk)
    cnt <= reset || cnt == IDX_W'(TLBNUM - 1) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tlb_op_seq.sv
// tlb_op_seq: multi-cycle sequencer driving TLB and CSR ports for committed TLB ops
module tlb_op_seq
  import tlb_op_seq_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic [4:0]       req_inv_op,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic [IDX_W-1:0] tlb_r_index,
  input  logic             tlb_r_e,
  output logic             csr_rd_we,
  output logic             csr_rd_ne,
  output logic             tlb_inv_en,
  output logic [IDX_W-1:0] tlb_inv_index,
  output logic [4:0]       tlb_inv_op
);
  state_t           state, state_n;
  logic [IDX_W-1:0] fill_ctr, idx_q, scan_ctr;
  logic [4:0]       inv_op_q;
  logic             accept;
  tlb_fill_ctr #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) u_fill_ctr (
    .clk  (clk),
    .reset(reset),
    .cnt  (fill_ctr)
  );
  assign accept = state == S_IDLE && req_valid;
  // state register, scan counter and op latches; FILL captures the victim index at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx_q    <= '0;
      inv_op_q <= '0;
      scan_ctr <= '0;
    end else begin
      state    <= state_n;
      scan_ctr <= state == S_INV_SCAN && state_n == S_INV_SCAN ? scan_ctr + 1'b1 : '0;
      if (accept) begin
        idx_q    <= req_op == OP_FILL ? fill_ctr : req_index;
        inv_op_q <= req_inv_op;
      end
    end
  end
  // next-state decode; unsupported invtlb ops finish immediately with no TLB activity
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (req_valid)
          state_n = req_op == OP_RD  ? S_RD_ADDR :
                    req_op == OP_INV ? (req_inv_op <= INV_OP_MAX ? S_INV_SCAN : S_DONE) :
                    S_WRITE;
      S_RD_ADDR:  state_n = S_RD_CAP;
      S_RD_CAP:   state_n = S_DONE;
      S_WRITE:    state_n = S_DONE;
      S_INV_SCAN: state_n = scan_ctr == IDX_W'(TLBNUM - 1) ? S_DONE : S_INV_SCAN;
      default:    state_n = S_IDLE;
    endcase
  end
  assign req_ready     = state == S_IDLE;
  assign busy          = ~req_ready;
  assign done          = state == S_DONE;
  assign tlb_we        = state == S_WRITE;
  assign tlb_w_index   = tlb_we ? idx_q : '0;
  assign tlb_r_index   = state == S_RD_ADDR ? idx_q : '0;
  assign csr_rd_we     = state == S_RD_CAP;
  assign csr_rd_ne     = csr_rd_we & ~tlb_r_e;
  assign tlb_inv_en    = state == S_INV_SCAN;
  assign tlb_inv_index = tlb_inv_en ? scan_ctr : '0;
  assign tlb_inv_op    = inv_op_q;
endmodule

// File: tb/tb_tlb_op_seq.sv
// tb_tlb_op_seq: directed-step bench for the TLB op sequencer
module tb_tlb_op_seq;
  logic       clk = 0, reset = 1;
  logic       req_valid = 0, tlb_r_e = 0;
  logic [1:0] req_op = 0;
  logic [3:0] req_index = 0;
  logic [4:0] req_inv_op = 0;
  logic       req_ready, busy, done, tlb_we, csr_rd_we, csr_rd_ne, tlb_inv_en;
  logic [3:0] tlb_w_index, tlb_r_index, tlb_inv_index;
  logic [4:0] tlb_inv_op;
  int         n_cmp = 0, n_bad = 0, cyc = 0, c1 = 0, we_cnt = 0;

  tlb_op_seq #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_index(req_index), .req_inv_op(req_inv_op), .req_ready(req_ready),
    .busy(busy), .done(done), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .csr_rd_we(csr_rd_we),
    .csr_rd_ne(csr_rd_ne), .tlb_inv_en(tlb_inv_en), .tlb_inv_index(tlb_inv_index),
    .tlb_inv_op(tlb_inv_op)
  );

  always #5 clk = ~clk;

  // mirrors the free-running fill counter: cycles since reset, taken mod 16
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [4:0] iop);
    req_valid = 1; req_op = op; req_index = idx; req_inv_op = iop;
    step();
    req_valid = 0;
  endtask

  task automatic wait_fill15();
    for (int i = 0; i < 40 && cyc % 16 != 15; i++) step();
    chk("fill_wait_bound", 32'(cyc % 16), 15);
  endtask

  initial begin
    step(); step();
    reset = 0;
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", tlb_we, 0);
    chk("rst_inv_en", tlb_inv_en, 0);
    chk("rst_csr_we", csr_rd_we, 0);
    chk("rst_inv_op", tlb_inv_op, 0);

    issue(2'b01, 4'd5, 5'd0);
    chk("wr_we", tlb_we, 1);
    chk("wr_idx", tlb_w_index, 5);
    chk("wr_busy", busy, 1);
    chk("wr_ready", req_ready, 0);
    step();
    chk("wr_done", done, 1);
    chk("wr_we_off", tlb_we, 0);
    chk("wr_idx_off", tlb_w_index, 0);
    step();
    chk("wr_ready_back", req_ready, 1);
    chk("wr_done_off", done, 0);

    tlb_r_e = 0;
    issue(2'b00, 4'd9, 5'd0);
    chk("rd_ridx", tlb_r_index, 9);
    chk("rd_csr_early", csr_rd_we, 0);
    step();
    chk("rd_csr_we", csr_rd_we, 1);
    chk("rd_ne", csr_rd_ne, 1);
    chk("rd_ridx_off", tlb_r_index, 0);
    step();
    chk("rd_done", done, 1);
    chk("rd_csr_off", csr_rd_we, 0);
    step();
    tlb_r_e = 1;
    issue(2'b00, 4'd3, 5'd0);
    chk("rd2_ridx", tlb_r_index, 3);
    step();
    chk("rd2_ne", csr_rd_ne, 0);
    step(); step();
    tlb_r_e = 0;

    wait_fill15();
    c1 = cyc;
    issue(2'b10, 4'd2, 5'd0);
    chk("fill1_we", tlb_we, 1);
    chk("fill1_idx", tlb_w_index, 15);
    step();
    chk("fill1_done", done, 1);
    for (int i = 0; i < 40 && cyc != c1 + 16; i++) step();
    chk("fill2_gap", 32'(cyc - c1), 16);
    issue(2'b10, 4'd7, 5'd0);
    chk("fill2_idx", tlb_w_index, 15);
    step(); step();

    issue(2'b11, 4'd0, 5'd5);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("inv_en_%0d", i), tlb_inv_en, 1);
      chk($sformatf("inv_idx_%0d", i), tlb_inv_index, i);
      chk($sformatf("inv_op_%0d", i), tlb_inv_op, 5);
      step();
    end
    chk("inv_done", done, 1);
    chk("inv_en_off", tlb_inv_en, 0);
    step();
    chk("inv_ready", req_ready, 1);

    issue(2'b11, 4'd0, 5'd7);
    chk("bad_inv_done", done, 1);
    chk("bad_inv_en", tlb_inv_en, 0);
    step();

    issue(2'b11, 4'd0, 5'd2);
    for (int i = 0; i < 6; i++) step();
    chk("abort_idx6", tlb_inv_index, 6);
    reset = 1;
    step();
    chk("abort_en", tlb_inv_en, 0);
    chk("abort_busy", busy, 0);
    reset = 0;
    step();
    chk("abort_ready", req_ready, 1);
    chk("abort_en2", tlb_inv_en, 0);
    chk("abort_idx0", tlb_inv_index, 0);
    chk("abort_done", done, 0);
    chk("abort_inv_op", tlb_inv_op, 0);

    req_valid = 1; req_op = 2'b01; req_index = 4'd11;
    we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      we_cnt += int'(tlb_we);
    end
    chk("hold_one_we", we_cnt, 1);
    chk("hold_ready_after_done", req_ready, 1);
    step();
    req_valid = 0;
    chk("hold_second_we", tlb_we, 1);
    chk("hold_second_idx", tlb_w_index, 11);
    step(); step();
    chk("hold_idle", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
